calc_requester: RTL and testbench

CALC_REQUESTER -- requirements
Module: calc_requester

---
 rtl/calc_pkg.sv | 16 +
 rtl/sat_counter.sv | 26 ++
 rtl/calc_requester.sv | 117 +++++++++++
 tb/tb_calc_requester.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculation requester and the calculation engine bench:
// requester FSM state encoding and the default watchdog limit.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RELEASE,
        RESULT
    } calc_state_t;

    // Watchdog limit in WAIT_DONE cycles: two seconds at 50 MHz.
    localparam logic [31:0] CALC_TIMEOUT_CYCLES = 32'd100000000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Serves as both the watchdog and the request latency counter.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    // Clear wins over enable; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != ALL_ONES)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/calc_requester.sv
// Calculation requester: accepts a bound from upstream, drives the calculation
// engine with a start level, waits for completion (guarded by a watchdog), waits
// for the engine to drop its done level, then presents the captured result
// downstream until it is accepted.
module calc_requester
    import calc_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = CALC_TIMEOUT_CYCLES,
    parameter int          W              = 32
) (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    input  logic         req_valid,
    input  logic [W-1:0] req_max,
    output logic         req_ready,
    output logic         calc_start,
    output logic [W-1:0] calc_max,
    input  logic [W-1:0] calc_sum,
    input  logic         calc_done,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_sum,
    output logic [W-1:0] res_cycles,
    output logic         res_timeout
);

    localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT_CYCLES);

    calc_state_t  state;
    logic [W-1:0] count;
    logic         accept;
    logic         cnt_en;

    // New requests are only taken while idle, so a result is never overwritten
    // before its handshake completes.
    always_comb begin
        req_ready = (state == IDLE);
        accept    = (state == IDLE) && req_valid;
        cnt_en    = (state == WAIT_DONE);
    end

    sat_counter #(
        .W (W)
    ) u_cycle_cnt (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .clr   (accept),
        .en    (cnt_en),
        .count (count)
    );

    // Request sequencing FSM; every output is registered so the engine sees
    // glitch-free start/bound levels and calc_max only moves on an accept.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            calc_start  <= 1'b0;
            calc_max    <= '0;
            res_valid   <= 1'b0;
            res_sum     <= '0;
            res_cycles  <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A done level left over from a previous run is ignored here.
                    if (req_valid) begin
                        calc_max   <= req_max;
                        calc_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // One cycle for the engine to see the start edge before
                    // done is trusted; stale done levels are ignored here too.
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // Completion takes priority over a watchdog expiry in the same cycle.
                    if (calc_done) begin
                        res_sum     <= calc_sum;
                        res_cycles  <= count;
                        res_timeout <= 1'b0;
                        calc_start  <= 1'b0;
                        state       <= RELEASE;
                    end else if (count == TIMEOUT_W) begin
                        res_sum     <= '0;
                        res_cycles  <= count;
                        res_timeout <= 1'b1;
                        calc_start  <= 1'b0;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Wait for the engine to drop done so the next request
                    // cannot mistake the old level for a new completion.
                    if (!calc_done) begin
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    calc_start <= 1'b0;
                    res_valid  <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_requester.sv
// Self-checking bench for calc_requester. Two requesters are built: one with the
// default watchdog and one with a 50-cycle watchdog, each attached to a
// behavioural model of the calculation engine (sum of all i < max with i a
// multiple of 3 or 5, two clocks per iteration, reset by ~reset_n).
module tb_calc_requester;

    localparam int W = 32;

    logic         CLOCK_50 = 1'b0;
    logic         reset_n;
    logic         eng_rst;

    logic         req_valid   [2];
    logic [W-1:0] req_max     [2];
    logic         req_ready   [2];
    logic         calc_start  [2];
    logic [W-1:0] calc_max    [2];
    logic [W-1:0] calc_sum    [2];
    logic         calc_done   [2];
    logic         res_valid   [2];
    logic         res_ready   [2];
    logic [W-1:0] res_sum     [2];
    logic [W-1:0] res_cycles  [2];
    logic         res_timeout [2];

    logic         eng_busy [2];
    logic         eng_ph   [2];
    logic [W-1:0] eng_i    [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] sb_q  [$];
    logic [W-1:0] got_q [$];
    int           sb_results = 0;
    int           viol_max   = 0;
    int           viol_order = 0;
    logic         prev_start [2];
    logic [W-1:0] prev_max   [2];

    always #10 CLOCK_50 = ~CLOCK_50;

    assign eng_rst = ~reset_n;

    calc_requester #(
        .W (W)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .req_valid   (req_valid[0]),
        .req_max     (req_max[0]),
        .req_ready   (req_ready[0]),
        .calc_start  (calc_start[0]),
        .calc_max    (calc_max[0]),
        .calc_sum    (calc_sum[0]),
        .calc_done   (calc_done[0]),
        .res_valid   (res_valid[0]),
        .res_ready   (res_ready[0]),
        .res_sum     (res_sum[0]),
        .res_cycles  (res_cycles[0]),
        .res_timeout (res_timeout[0])
    );

    calc_requester #(
        .TIMEOUT_CYCLES (32'd50),
        .W              (W)
    ) dut_to (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .req_valid   (req_valid[1]),
        .req_max     (req_max[1]),
        .req_ready   (req_ready[1]),
        .calc_start  (calc_start[1]),
        .calc_max    (calc_max[1]),
        .calc_sum    (calc_sum[1]),
        .calc_done   (calc_done[1]),
        .res_valid   (res_valid[1]),
        .res_ready   (res_ready[1]),
        .res_sum     (res_sum[1]),
        .res_cycles  (res_cycles[1]),
        .res_timeout (res_timeout[1])
    );

    // Engine model: starts on a new start level, iterates i = 0 .. max-1 at two
    // clocks per step, holds done until start drops, aborts when start drops.
    always @(posedge CLOCK_50 or posedge eng_rst) begin
        for (int g = 0; g < 2; g++) begin
            if (eng_rst) begin
                eng_busy[g]  <= 1'b0;
                eng_ph[g]    <= 1'b0;
                eng_i[g]     <= '0;
                calc_sum[g]  <= '0;
                calc_done[g] <= 1'b0;
            end else if (!calc_start[g]) begin
                eng_busy[g]  <= 1'b0;
                calc_done[g] <= 1'b0;
            end else if (!eng_busy[g] && !calc_done[g]) begin
                eng_busy[g] <= 1'b1;
                eng_ph[g]   <= 1'b0;
                eng_i[g]    <= '0;
                calc_sum[g] <= '0;
            end else if (eng_busy[g]) begin
                if (eng_i[g] >= calc_max[g]) begin
                    eng_busy[g]  <= 1'b0;
                    calc_done[g] <= 1'b1;
                end else if (eng_ph[g]) begin
                    eng_ph[g] <= 1'b0;
                    eng_i[g]  <= eng_i[g] + 1;
                    if ((eng_i[g] % 3 == 0) || (eng_i[g] % 5 == 0))
                        calc_sum[g] <= calc_sum[g] + eng_i[g];
                end else begin
                    eng_ph[g] <= 1'b1;
                end
            end
        end
    end

    function automatic logic [W-1:0] ref_sum(input logic [W-1:0] mx);
        logic [W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < mx; i++)
            if ((i % 3 == 0) || (i % 5 == 0)) s = s + W'(i);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Scoreboard on the default-watchdog requester plus protocol monitors on both.
    always @(negedge CLOCK_50) begin
        if (!reset_n) begin
            sb_q.delete();
        end else begin
            if (req_valid[0] && req_ready[0]) sb_q.push_back(req_max[0]);
            if (res_valid[0] && res_ready[0]) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_result", 1, 0);
                end else begin
                    logic [W-1:0] mx;
                    mx = sb_q.pop_front();
                    chk("sb_sum", res_sum[0], ref_sum(mx));
                    chk("sb_timeout", res_timeout[0], 0);
                end
                got_q.push_back(res_sum[0]);
                sb_results++;
            end
            for (int k = 0; k < 2; k++) begin
                if (calc_start[k] && prev_start[k] && (calc_max[k] != prev_max[k])) viol_max++;
                if (res_valid[k] && calc_start[k]) viol_order++;
            end
        end
        for (int k = 0; k < 2; k++) begin
            prev_start[k] = calc_start[k];
            prev_max[k]   = calc_max[k];
        end
    end

    // Issue one request on requester k, hold the result for 'hold' cycles, then accept it.
    // Called and returns at #1 after a rising edge.
    task automatic run_req(input int k, input logic [W-1:0] mx, input int hold,
                           output logic [W-1:0] s, output logic [W-1:0] cyc,
                           output logic to, output int acc_wait);
        int   n;
        logic ok;
        req_max[k]   = mx;
        req_valid[k] = 1'b1;
        res_ready[k] = 1'b0;
        n = 0;
        while (!req_ready[k] && n < 1000) begin
            @(posedge CLOCK_50); #1;
            n++;
        end
        acc_wait = n;
        @(posedge CLOCK_50); #1;
        req_valid[k] = 1'b0;
        chk("accepted", req_ready[k], 0);
        n = 0;
        while (!res_valid[k] && n < 5000) begin
            @(posedge CLOCK_50); #1;
            n++;
        end
        if (n >= 5000) chk("res_valid_wait_expired", 0, 1);
        chk("start_low_at_result", calc_start[k], 0);
        s   = res_sum[k];
        cyc = res_cycles[k];
        to  = res_timeout[k];
        ok  = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLOCK_50); #1;
            if (!res_valid[k] || req_ready[k] || res_sum[k] != s ||
                res_cycles[k] != cyc || res_timeout[k] != to) ok = 1'b0;
        end
        if (hold > 0) chk("result_held_stable", ok, 1);
        res_ready[k] = 1'b1;
        @(posedge CLOCK_50); #1;
        res_ready[k] = 1'b0;
        chk("res_valid_dropped", res_valid[k], 0);
        chk("ready_after_handshake", req_ready[k], 1);
    endtask

    function automatic logic in_window(input logic [W-1:0] cyc, input logic [W-1:0] mx);
        int c, e;
        c = int'(cyc);
        e = 2 * int'(mx);
        return (c >= e - 4) && (c <= e + 4);
    endfunction

    initial begin
        #(20 * 60000);
        $display("FAIL global_time_limit got=%0d exp=%0d", 1, 0);
        $fatal(1, "time limit");
    end

    initial begin
        logic [W-1:0] s, cyc, mx;
        logic         to, ok;
        int           aw, n, base, hold;
        logic [W-1:0] b2b [3];

        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_max[k]   = '0;
            res_ready[k] = 1'b0;
        end
        #1 reset_n = 1'b0;
        #4;
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", req_ready[k], 1);
            chk("rst_calc_start", calc_start[k], 0);
            chk("rst_calc_max", calc_max[k], 0);
            chk("rst_res_valid", res_valid[k], 0);
            chk("rst_res_sum", res_sum[k], 0);
            chk("rst_res_cycles", res_cycles[k], 0);
            chk("rst_res_timeout", res_timeout[k], 0);
        end
        repeat (3) @(posedge CLOCK_50);
        #1 reset_n = 1'b1;

        // Basic request straight after reset: accepted on the first edge.
        run_req(0, 10, 0, s, cyc, to, aw);
        chk("first_accept_wait", aw, 0);
        chk("max10_sum", s, 23);
        chk("max10_timeout", to, 0);

        // Long request and latency measurement.
        run_req(0, 1000, 0, s, cyc, to, aw);
        chk("max1000_sum", s, 233168);
        chk("max1000_cycles_window", in_window(cyc, 1000), 1);

        // Downstream backpressure for 20 cycles.
        run_req(0, 16, 20, s, cyc, to, aw);
        chk("max16_sum", s, 60);

        // Watchdog abort on the 50-cycle requester, then a normal request.
        run_req(1, 1000, 0, s, cyc, to, aw);
        chk("wd_timeout", to, 1);
        chk("wd_sum", s, 0);
        chk("wd_cycles", cyc, 50);
        run_req(1, 10, 0, s, cyc, to, aw);
        chk("after_wd_sum", s, 23);
        chk("after_wd_timeout", to, 0);

        // Reset pulse while waiting for the engine.
        req_max[0]   = 1000;
        req_valid[0] = 1'b1;
        @(posedge CLOCK_50); #1;
        req_valid[0] = 1'b0;
        repeat (30) @(posedge CLOCK_50);
        #1;
        chk("midop_start_high", calc_start[0], 1);
        reset_n = 1'b0;
        #1;
        chk("midop_start_dropped", calc_start[0], 0);
        chk("midop_calc_max_cleared", calc_max[0], 0);
        chk("midop_ready", req_ready[0], 1);
        @(posedge CLOCK_50); #1;
        reset_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLOCK_50); #1;
            if (res_valid[0]) ok = 1'b0;
        end
        chk("midop_no_result", ok, 1);
        run_req(0, 2, 0, s, cyc, to, aw);
        chk("after_rst_max2_sum", s, 0);

        // Back-to-back requests with req_valid held high.
        b2b[0] = 10; b2b[1] = 16; b2b[2] = 0;
        got_q.delete();
        base = sb_results;
        res_ready[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            req_max[0]   = b2b[j];
            req_valid[0] = 1'b1;
            n = 0;
            while (!req_ready[0] && n < 1000) begin
                @(posedge CLOCK_50); #1;
                n++;
            end
            @(posedge CLOCK_50); #1;
        end
        req_valid[0] = 1'b0;
        n = 0;
        while (sb_results < base + 3 && n < 2000) begin
            @(posedge CLOCK_50); #1;
            n++;
        end
        res_ready[0] = 1'b0;
        chk("b2b_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("b2b_sum0", got_q[0], 23);
            chk("b2b_sum1", got_q[1], 60);
            chk("b2b_sum2", got_q[2], 0);
        end

        // Randomised requests with random downstream backpressure.
        for (int r = 0; r < 15; r++) begin
            mx   = W'($urandom_range(0, 60));
            hold = int'($urandom_range(0, 3));
            run_req(0, mx, hold, s, cyc, to, aw);
            chk("rand_sum", s, ref_sum(mx));
            chk("rand_timeout", to, 0);
            chk("rand_cycles_window", in_window(cyc, mx), 1);
        end

        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("calc_max_stable_while_start", viol_max, 0);
        chk("start_low_while_res_valid", viol_order, 0);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
